// File: rtl/vga_timing_gen.sv
// VGA raster timing generator with programmable pixel-clock divider and a
// four-way pattern source, driving the ADV7123 DAC pins on the DE2 board.
module vga_timing_gen #(
    parameter int   CLK_DIV  = 2,
    parameter int   H_ACTIVE = 640,
    parameter int   H_FP     = 16,
    parameter int   H_SYNC   = 96,
    parameter int   H_BP     = 48,
    parameter int   V_ACTIVE = 480,
    parameter int   V_FP     = 10,
    parameter int   V_SYNC   = 2,
    parameter int   V_BP     = 33,
    parameter logic HS_POL   = 1'b0,
    parameter logic VS_POL   = 1'b0,
    parameter int   CHK_LOG2 = 5,
    parameter int   COLOR_W  = 10
) (
    input  logic               clk50m,
    input  logic               rst,
    input  logic [1:0]         mode,
    input  logic [COLOR_W-1:0] ext_r,
    input  logic [COLOR_W-1:0] ext_g,
    input  logic [COLOR_W-1:0] ext_b,
    output logic [11:0]        pix_x,
    output logic [11:0]        pix_y,
    output logic               pix_req,
    output logic               frame_start,
    output logic               VGA_CLK,
    output logic               VGA_HS,
    output logic               VGA_VS,
    output logic               VGA_BLANK,
    output logic               VGA_SYNC,
    output logic [COLOR_W-1:0] VGA_R,
    output logic [COLOR_W-1:0] VGA_G,
    output logic [COLOR_W-1:0] VGA_B
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DW      = $clog2(CLK_DIV);
    localparam int BAR_W   = H_ACTIVE / 8;

    logic [DW-1:0]      dcnt;
    logic [DW-1:0]      dcnt_nxt;
    logic               pe;
    logic [11:0]        hcnt;
    logic [11:0]        vcnt;
    logic               h_wrap;
    logic               v_wrap;
    logic               first_px;
    logic [11:0]        bar_pos;
    logic [2:0]         bar_idx;
    logic [1:0]         mode_q;
    logic [1:0]         mode_eff;
    logic               hs_on;
    logic               vs_on;
    logic               chk;
    logic [COLOR_W-1:0] src_r;
    logic [COLOR_W-1:0] src_g;
    logic [COLOR_W-1:0] src_b;

    assign pe       = (dcnt == DW'(CLK_DIV - 1));
    assign dcnt_nxt = pe ? '0 : dcnt + 1'b1;

    // VGA_CLK follows the next divider state so it falls as new pixel data
    // lands and rises mid-pixel, centring the DAC setup window.
    always_ff @(posedge clk50m) begin
        if (rst) begin
            dcnt    <= '0;
            VGA_CLK <= 1'b0;
        end else begin
            dcnt    <= dcnt_nxt;
            VGA_CLK <= (dcnt_nxt >= DW'(CLK_DIV / 2));
        end
    end

    assign h_wrap   = (hcnt == 12'(H_TOTAL - 1));
    assign v_wrap   = (vcnt == 12'(V_TOTAL - 1));
    assign first_px = (hcnt == 12'd0) && (vcnt == 12'd0);

    always_ff @(posedge clk50m) begin
        if (rst) begin
            hcnt    <= '0;
            vcnt    <= '0;
            bar_pos <= '0;
            bar_idx <= '0;
            mode_q  <= '0;
        end else if (pe) begin
            hcnt <= h_wrap ? 12'd0 : hcnt + 12'd1;
            if (h_wrap)
                vcnt <= v_wrap ? 12'd0 : vcnt + 12'd1;
            if (h_wrap) begin
                bar_pos <= '0;
                bar_idx <= '0;
            end else if (bar_pos == 12'(BAR_W - 1)) begin
                bar_pos <= '0;
                bar_idx <= bar_idx + 3'd1;
            end else begin
                bar_pos <= bar_pos + 12'd1;
            end
            if (first_px)
                mode_q <= mode;
        end
    end

    assign pix_x    = hcnt;
    assign pix_y    = vcnt;
    assign pix_req  = ({1'b0, hcnt} < 13'(H_ACTIVE)) && ({1'b0, vcnt} < 13'(V_ACTIVE));
    assign hs_on    = ({1'b0, hcnt} >= 13'(H_ACTIVE + H_FP)) &&
                      ({1'b0, hcnt} <  13'(H_ACTIVE + H_FP + H_SYNC));
    assign vs_on    = ({1'b0, vcnt} >= 13'(V_ACTIVE + V_FP)) &&
                      ({1'b0, vcnt} <  13'(V_ACTIVE + V_FP + V_SYNC));
    // The first pixel of a frame already uses the newly sampled mode.
    assign mode_eff = first_px ? mode : mode_q;
    assign chk      = hcnt[CHK_LOG2] ^ vcnt[CHK_LOG2];
    assign VGA_SYNC = 1'b0;

    always_comb begin
        src_r = '0;
        src_g = '0;
        src_b = '0;
        case (mode_eff)
            2'd1: begin
                src_r = {COLOR_W{~bar_idx[1]}};
                src_g = {COLOR_W{~bar_idx[2]}};
                src_b = {COLOR_W{~bar_idx[0]}};
            end
            2'd2: begin
                src_r = {COLOR_W{chk}};
                src_g = {COLOR_W{chk}};
                src_b = {COLOR_W{chk}};
            end
            2'd3: begin
                src_r = ext_r;
                src_g = ext_g;
                src_b = ext_b;
            end
            default: begin
                src_r = '0;
                src_g = '0;
                src_b = '0;
            end
        endcase
    end

    always_ff @(posedge clk50m) begin
        if (rst) begin
            VGA_HS      <= ~HS_POL;
            VGA_VS      <= ~VS_POL;
            VGA_BLANK   <= 1'b0;
            VGA_R       <= '0;
            VGA_G       <= '0;
            VGA_B       <= '0;
            frame_start <= 1'b0;
        end else begin
            frame_start <= pe && h_wrap && v_wrap;
            if (pe) begin
                VGA_HS    <= hs_on ? HS_POL : ~HS_POL;
                VGA_VS    <= vs_on ? VS_POL : ~VS_POL;
                VGA_BLANK <= pix_req;
                VGA_R     <= pix_req ? src_r : '0;
                VGA_G     <= pix_req ? src_g : '0;
                VGA_B     <= pix_req ? src_b : '0;
            end
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: default timing, a shrunken raster for
// frame-level behaviour, and a CLK_DIV=4 / positive-sync variant.
module tb_vga_timing_gen;

    localparam int LIM = 20000;

    typedef struct {
        string      name;
        int         dut;
        int         x;
        int         y;
        logic       blank;
        logic [9:0] r;
        logic [9:0] g;
        logic [9:0] b;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic       rst_d, rst_s, rst_w;
    logic [1:0] mode_d, mode_s, mode_w;
    logic [9:0] ext_zero;
    logic [9:0] ext_r_d, ext_g_d, ext_b_d;

    logic [11:0] pix_x_d, pix_y_d, pix_x_s, pix_y_s, pix_x_w, pix_y_w;
    logic        req_d, req_s, req_w, fs_d, fs_s, fs_w;
    logic        vclk_d, vclk_s, vclk_w, hs_d, hs_s, hs_w, vs_d, vs_s, vs_w;
    logic        blank_d, blank_s, blank_w, sync_d, sync_s, sync_w;
    logic [9:0]  r_d, g_d, b_d, r_s, g_s, b_s, r_w, g_w, b_w;

    // External source model: red follows the column, green its complement.
    assign ext_r_d = pix_x_d[9:0];
    assign ext_g_d = ~pix_x_d[9:0];
    assign ext_b_d = 10'h155;

    vga_timing_gen dut_d (
        .clk50m(clk), .rst(rst_d), .mode(mode_d),
        .ext_r(ext_r_d), .ext_g(ext_g_d), .ext_b(ext_b_d),
        .pix_x(pix_x_d), .pix_y(pix_y_d), .pix_req(req_d), .frame_start(fs_d),
        .VGA_CLK(vclk_d), .VGA_HS(hs_d), .VGA_VS(vs_d), .VGA_BLANK(blank_d),
        .VGA_SYNC(sync_d), .VGA_R(r_d), .VGA_G(g_d), .VGA_B(b_d)
    );

    vga_timing_gen #(
        .H_ACTIVE(64), .H_FP(4), .H_SYNC(8), .H_BP(4),
        .V_ACTIVE(48), .V_FP(2), .V_SYNC(2), .V_BP(3), .CHK_LOG2(3)
    ) dut_s (
        .clk50m(clk), .rst(rst_s), .mode(mode_s),
        .ext_r(ext_zero), .ext_g(ext_zero), .ext_b(ext_zero),
        .pix_x(pix_x_s), .pix_y(pix_y_s), .pix_req(req_s), .frame_start(fs_s),
        .VGA_CLK(vclk_s), .VGA_HS(hs_s), .VGA_VS(vs_s), .VGA_BLANK(blank_s),
        .VGA_SYNC(sync_s), .VGA_R(r_s), .VGA_G(g_s), .VGA_B(b_s)
    );

    vga_timing_gen #(
        .CLK_DIV(4), .H_ACTIVE(320), .HS_POL(1'b1), .VS_POL(1'b1)
    ) dut_w (
        .clk50m(clk), .rst(rst_w), .mode(mode_w),
        .ext_r(ext_zero), .ext_g(ext_zero), .ext_b(ext_zero),
        .pix_x(pix_x_w), .pix_y(pix_y_w), .pix_req(req_w), .frame_start(fs_w),
        .VGA_CLK(vclk_w), .VGA_HS(hs_w), .VGA_VS(vs_w), .VGA_BLANK(blank_w),
        .VGA_SYNC(sync_w), .VGA_R(r_w), .VGA_G(g_w), .VGA_B(b_w)
    );

    int          sel = 0;
    logic [11:0] v_pix_x, v_pix_y;
    logic        v_blank;
    logic [9:0]  v_r, v_g, v_b;

    always_comb begin
        v_pix_x = pix_x_d; v_pix_y = pix_y_d; v_blank = blank_d;
        v_r = r_d; v_g = g_d; v_b = b_d;
        if (sel == 1) begin
            v_pix_x = pix_x_s; v_pix_y = pix_y_s; v_blank = blank_s;
            v_r = r_s; v_g = g_s; v_b = b_s;
        end
    end

    int   probe_sel = 0;
    logic probe;

    always_comb begin
        case (probe_sel)
            0:       probe = blank_d;
            1:       probe = hs_d;
            2:       probe = hs_w;
            3:       probe = fs_s;
            default: probe = vs_s;
        endcase
    end

    vec_t vecs[$];

    function automatic void addVec(string n, int d, int x, int y, logic bl,
                                   logic [9:0] r, logic [9:0] g, logic [9:0] b);
        vec_t v;
        v.name = n; v.dut = d; v.x = x; v.y = y;
        v.blank = bl; v.r = r; v.g = g; v.b = b;
        vecs.push_back(v);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)",
                     name, actual, actual, expected, expected);
        end
    endtask

    // Wait until the selected DUT shows pixel (x,y), then until the counters
    // move on; at that point the output register holds that pixel.
    task automatic waitPixel(input int x, input int y, output bit ok);
        int n;
        ok = 1'b0;
        n  = 0;
        while (!(v_pix_x == 12'(x) && v_pix_y == 12'(y)) && n < LIM) begin
            @(negedge clk);
            n++;
        end
        if (n >= LIM) return;
        n = 0;
        while (v_pix_x == 12'(x) && n < LIM) begin
            @(negedge clk);
            n++;
        end
        ok = (n < LIM);
    endtask

    task automatic applyStimulus(input vec_t v);
        bit ok;
        sel = v.dut;
        waitPixel(v.x, v.y, ok);
        if (!ok) begin
            checkOutput({v.name, "_reached"}, 0, 1);
            return;
        end
        checkOutput({v.name, "_blank"}, 32'(v_blank), 32'(v.blank));
        checkOutput({v.name, "_r"}, 32'(v_r), 32'(v.r));
        checkOutput({v.name, "_g"}, 32'(v_g), 32'(v.g));
        checkOutput({v.name, "_b"}, 32'(v_b), 32'(v.b));
    endtask

    // Length of one complete run at lvl on the probe, plus the full period.
    task automatic measureRun(input logic lvl, output int width, output int period);
        int n;
        int gap;
        width  = -1;
        period = -1;
        n = 0;
        while (probe == lvl && n < LIM) begin @(negedge clk); n++; end
        n = 0;
        while (probe != lvl && n < LIM) begin @(negedge clk); n++; end
        if (n >= LIM) return;
        width = 0;
        while (probe == lvl && width < LIM) begin @(negedge clk); width++; end
        gap = 0;
        while (probe != lvl && gap < LIM) begin @(negedge clk); gap++; end
        period = width + gap;
    endtask

    // Every run of VGA_CLK after the first must last exp_run cycles, and
    // pixel counters may only change while VGA_CLK is low.
    task automatic checkClockRuns(input string name, input int which, input int exp_run);
        logic        prev, cur;
        logic [11:0] px_prev, px;
        int          run, bad;
        bit          first;
        prev    = (which == 0) ? vclk_d : vclk_w;
        px_prev = (which == 0) ? pix_x_d : pix_x_w;
        run = 1; bad = 0; first = 1'b1;
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            cur = (which == 0) ? vclk_d : vclk_w;
            px  = (which == 0) ? pix_x_d : pix_x_w;
            if (px != px_prev && cur != 1'b0) bad++;
            if (cur == prev) run++;
            else begin
                if (!first && run != exp_run) bad++;
                first = 1'b0;
                run   = 1;
            end
            prev    = cur;
            px_prev = px;
        end
        if (first) bad++;
        checkOutput(name, bad, 0);
    endtask

    initial begin
        int width, period, first_d, first_w, bad, n, pe_n, fs_n;
        int bars_end, m3_end;
        bit ok;

        rst_d = 1'b1; rst_s = 1'b1; rst_w = 1'b1;
        mode_d = 2'd1; mode_s = 2'd1; mode_w = 2'd1;
        ext_zero = '0;

        addVec("bar_x0",     0,   0, 1, 1'b1, 10'h3FF, 10'h3FF, 10'h3FF);
        addVec("bar_x79",    0,  79, 1, 1'b1, 10'h3FF, 10'h3FF, 10'h3FF);
        addVec("bar_x80",    0,  80, 1, 1'b1, 10'h3FF, 10'h3FF, 10'h000);
        addVec("bar_x159",   0, 159, 1, 1'b1, 10'h3FF, 10'h3FF, 10'h000);
        addVec("bar_x160",   0, 160, 1, 1'b1, 10'h000, 10'h3FF, 10'h3FF);
        addVec("bar_x240",   0, 240, 1, 1'b1, 10'h000, 10'h3FF, 10'h000);
        addVec("bar_x320",   0, 320, 1, 1'b1, 10'h3FF, 10'h000, 10'h3FF);
        addVec("bar_x400",   0, 400, 1, 1'b1, 10'h3FF, 10'h000, 10'h000);
        addVec("bar_x480",   0, 480, 1, 1'b1, 10'h000, 10'h000, 10'h3FF);
        addVec("bar_x560",   0, 560, 1, 1'b1, 10'h000, 10'h000, 10'h000);
        addVec("bar_x639",   0, 639, 1, 1'b1, 10'h000, 10'h000, 10'h000);
        addVec("bar_x640",   0, 640, 1, 1'b0, 10'h000, 10'h000, 10'h000);
        addVec("bar_x799",   0, 799, 1, 1'b0, 10'h000, 10'h000, 10'h000);
        bars_end = vecs.size();
        addVec("ext_x5",     0,   5, 0, 1'b1, 10'h005, 10'h3FA, 10'h155);
        addVec("ext_x6",     0,   6, 0, 1'b1, 10'h006, 10'h3F9, 10'h155);
        addVec("ext_x639",   0, 639, 0, 1'b1, 10'h27F, 10'h180, 10'h155);
        addVec("ext_x640",   0, 640, 0, 1'b0, 10'h000, 10'h000, 10'h000);
        m3_end = vecs.size();
        addVec("mc_bar_8_30", 1,  8, 30, 1'b1, 10'h3FF, 10'h3FF, 10'h000);
        addVec("mc_chk_0_0",  1,  0,  0, 1'b1, 10'h000, 10'h000, 10'h000);
        addVec("mc_chk_8_0",  1,  8,  0, 1'b1, 10'h3FF, 10'h3FF, 10'h3FF);
        addVec("mc_chk_0_8",  1,  0,  8, 1'b1, 10'h3FF, 10'h3FF, 10'h3FF);
        addVec("mc_chk_8_8",  1,  8,  8, 1'b1, 10'h000, 10'h000, 10'h000);
        addVec("mc_chk_20_47",1, 20, 47, 1'b1, 10'h3FF, 10'h3FF, 10'h3FF);
        addVec("mc_x64_47",   1, 64, 47, 1'b0, 10'h000, 10'h000, 10'h000);

        repeat (3) @(negedge clk);
        checkOutput("rst_hs_d",    32'(hs_d),    1);
        checkOutput("rst_vs_d",    32'(vs_d),    1);
        checkOutput("rst_blank_d", 32'(blank_d), 0);
        checkOutput("rst_rgb_d",   32'({r_d, g_d, b_d}), 0);
        checkOutput("rst_vclk_d",  32'(vclk_d),  0);
        checkOutput("rst_fs_d",    32'(fs_d),    0);
        checkOutput("rst_pix_x_d", 32'(pix_x_d), 0);
        checkOutput("rst_hs_w",    32'(hs_w),    0);
        checkOutput("rst_vs_w",    32'(vs_w),    0);
        checkOutput("sync_d",      32'(sync_d),  0);
        rst_d = 1'b0; rst_s = 1'b0; rst_w = 1'b0;

        first_d = -1;
        first_w = -1;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (first_d < 0 && pix_x_d == 12'd1) first_d = i;
            if (first_w < 0 && pix_x_w == 12'd1) first_w = i;
        end
        checkOutput("first_pe_d", first_d, 2);
        checkOutput("first_pe_w", first_w, 4);

        checkClockRuns("vclk_runs_d", 0, 1);
        checkClockRuns("vclk_runs_w", 1, 2);

        for (int i = 0; i < bars_end; i++) applyStimulus(vecs[i]);

        probe_sel = 0;
        measureRun(1'b1, width, period);
        checkOutput("blank_width_d", width, 1280);
        probe_sel = 1;
        measureRun(1'b0, width, period);
        checkOutput("hs_width_d",  width,  192);
        checkOutput("hs_period_d", period, 1600);

        probe_sel = 2;
        measureRun(1'b1, width, period);
        checkOutput("hs_width_w",  width,  384);
        checkOutput("hs_period_w", period, 1920);

        mode_d = 2'd3;
        rst_d  = 1'b1;
        @(negedge clk);
        rst_d  = 1'b0;
        for (int i = bars_end; i < m3_end; i++) applyStimulus(vecs[i]);
        bad = 0;
        for (int i = 0; i < 1700; i++) begin
            @(negedge clk);
            if (!blank_d && {r_d, g_d, b_d} != 30'd0) bad++;
        end
        checkOutput("blank_rgb_zero_d", bad, 0);

        probe_sel = 3;
        measureRun(1'b1, width, period);
        checkOutput("fs_width_s",  width,  1);
        checkOutput("fs_period_s", period, 8800);
        probe_sel = 4;
        measureRun(1'b0, width, period);
        checkOutput("vs_width_s",  width,  320);
        checkOutput("vs_period_s", period, 8800);

        n = 0;
        while (pix_y_s != 12'd20 && n < LIM) begin @(negedge clk); n++; end
        checkOutput("mc_line20_reached", 32'(n < LIM), 1);
        mode_s = 2'd2;
        for (int i = m3_end; i < vecs.size(); i++) applyStimulus(vecs[i]);

        n = 0;
        while (!(pix_x_s == 12'd40 && pix_y_s == 12'd20) && n < LIM) begin
            @(negedge clk);
            n++;
        end
        checkOutput("rst_point_reached", 32'(n < LIM), 1);
        rst_s = 1'b1;
        @(negedge clk);
        rst_s = 1'b0;
        checkOutput("mrst_pix_x", 32'(pix_x_s), 0);
        checkOutput("mrst_pix_y", 32'(pix_y_s), 0);
        checkOutput("mrst_hs",    32'(hs_s),    1);
        checkOutput("mrst_vs",    32'(vs_s),    1);
        checkOutput("mrst_blank", 32'(blank_s), 0);
        checkOutput("mrst_rgb",   32'({r_s, g_s, b_s}), 0);
        checkOutput("mrst_vclk",  32'(vclk_s),  0);
        checkOutput("mrst_fs",    32'(fs_s),    0);
        pe_n = -1;
        fs_n = -1;
        for (int i = 1; i <= 9000; i++) begin
            @(negedge clk);
            if (pe_n < 0 && pix_x_s == 12'd1) pe_n = i;
            if (fs_s) begin
                fs_n = i;
                break;
            end
        end
        checkOutput("mrst_first_pe", pe_n, 2);
        checkOutput("mrst_first_fs", fs_n, 8800);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Parametrised VGA raster timing generator and pattern source for the DE2 top level.
- Replaces the fixed divide-by-2 VGA_CLK toggle and tied-off sync pins with the following:
  - a programmable pixel-clock divider
  - full H/V sync, blank and sync generation
  - pixel coordinates
  - four selectable video sources: black, colour bars, checkerboard, and external pixel input
- Drives the ADV7123 DAC pins (VGA_*) directly.

Parameters:
- CLK_DIV, 2: clk50m cycles per pixel; even, ≥2 (2 gives 25 MHz).
- H_ACTIVE, 640: active pixels per line; must be a multiple of 8.
- H_FP, 16: horizontal front porch, in pixels.
- H_SYNC, 96: horizontal sync width, in pixels.
- H_BP, 48: horizontal back porch, in pixels.
- V_ACTIVE, 480: active lines.
- V_FP, 10: vertical front porch, in lines.
- V_SYNC, 2: vertical sync width, in lines.
- V_BP, 33: vertical back porch, in lines.
- HS_POL, 0: asserted level of VGA_HS.
- VS_POL, 0: asserted level of VGA_VS.
- CHK_LOG2, 5: checkerboard square size is 2^CHK_LOG2 pixels.
- COLOR_W, 10: width of each colour channel.

Ports:
- clk50m  in  1  system clock
- rst  in  1  synchronous reset, active high
- mode  in  2  source select: 0 black, 1 colour bars, 2 checkerboard, 3 external
- ext_r  in  COLOR_W  external red, used in mode 3
- ext_g  in  COLOR_W  external green, used in mode 3
- ext_b  in  COLOR_W  external blue, used in mode 3
- pix_x  out  12  current horizontal counter
- pix_y  out  12  current vertical counter
- pix_req  out  1  counters are inside the active area
- frame_start  out  1  one-clk50m pulse at the start of each frame
- VGA_CLK  out  1  pixel clock to the DAC
- VGA_HS  out  1  horizontal sync
- VGA_VS  out  1  vertical sync
- VGA_BLANK  out  1  blanking, low = blank
- VGA_SYNC  out  1  sync-on-green, held 0
- VGA_R  out  COLOR_W  red
- VGA_G  out  COLOR_W  green
- VGA_B  out  COLOR_W  blue

Behaviour:
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise. Both must be ≤4096. hcnt and vcnt are 12-bit.

Pixel clock:
- dcnt counts 0..CLK_DIV-1 and wraps.
- pe is high when dcnt == CLK_DIV-1.
- VGA_CLK is registered: 1 when dcnt ≥ CLK_DIV/2, else 0, i.e. 50% duty.
- Output registers change on pe, so VGA_CLK rises mid-pixel and the DAC setup is centred.

Counters:
- Counters advance only on pe.
- hcnt wraps H_TOTAL-1 → 0.
- vcnt increments when hcnt wraps, and itself wraps V_TOTAL-1 → 0.

Status outputs (combinational from the counters):
- pix_x = hcnt, pix_y = vcnt.
- pix_req = (hcnt < H_ACTIVE) && (vcnt < V_ACTIVE).

External data timing:
- ext_r/g/b are sampled at the pe that ends the pixel period in which pix_req and pix_x/pix_y showed that pixel.
- The source therefore has one pixel period (CLK_DIV cycles) to respond.

Output register, loaded on pe from the pre-advance counters:
- VGA_HS = HS_POL when H_ACTIVE+H_FP ≤ hcnt < H_ACTIVE+H_FP+H_SYNC, else ~HS_POL.
- VGA_VS: same rule using vcnt and the V_* parameters, with VS_POL.
- VGA_BLANK = pix_req.
- RGB = source value when pix_req, else 0.
- Latency from counter to pins is exactly one pixel. Sync, blank and colour stay aligned.

Sources:
- Mode 0: all channels 0.
- Mode 1: eight equal bars of width H_ACTIVE/8, left to right: white, yellow, cyan, green, magenta, red, blue, black.
  - Each channel is all-ones or 0.
  - Bar index comes from an incremental bar counter, not a divider.
  - The bar counter resets at hcnt 0.
- Mode 2: white when hcnt[CHK_LOG2] XOR vcnt[CHK_LOG2] = 1, else black.
- Mode 3: ext_r/g/b passed through unchanged.

Mode sampling:
- mode is registered into mode_q only at the pe where hcnt = 0 and vcnt = 0.
- A mid-frame mode change therefore takes effect at the next frame. There is no tearing.

frame_start:
- High for exactly one clk50m cycle: the cycle following the pe at which hcnt = vcnt = 0 is loaded.

VGA_SYNC: constant 0.

Reset (synchronous, takes effect at any point, including mid-line):
- dcnt, hcnt, vcnt and the bar counter = 0.
- mode_q = 0.
- VGA_CLK = 0.
- VGA_HS = ~HS_POL, VGA_VS = ~VS_POL.
- VGA_BLANK = 0, RGB = 0, frame_start = 0.
- The first pe after reset release occurs CLK_DIV cycles later.
- mode is captured at that first pe.

Test Plan:
- Defaults, run 2 frames:
  - pe period 2 cycles; VGA_CLK is a 25 MHz square wave.
  - HS low for 96 pixels (192 clk50m), with line period 800 pixels.
  - VS low for 2 lines, with frame period 525 lines = 840000 clk50m.
  - frame_start period 840000.
- Timing alignment, mode 1, defaults:
  - Pixels 0–79 output R = G = B = 0x3FF; pixels 80–159 output R = G = 0x3FF, B = 0.
  - Pixel 639 outputs all 0.
  - VGA_BLANK falls exactly 640 pixels after it rose.
  - RGB = 0 whenever BLANK = 0.
- Mode 3 with ext_r = pix_x[9:0]: at the pe after pix_x = 5 is shown, VGA_R = 5 (one-pixel latency).
  - ext values driven during blanking never appear on the pins.
- Mode changed from 1 to 2 at line 100: bars continue to the end of the frame.
  - Checkerboard starts at pixel (0,0) of the next frame.
  - At (32,0) the output is white; at (32,32) it is black.
- rst asserted for 1 cycle at hcnt = 400, vcnt = 200:
  - the next cycle shows all outputs at their reset values;
  - hcnt and vcnt restart from 0;
  - the first frame_start follows 840000 cycles after the first pe.
- CLK_DIV = 4, H_ACTIVE = 320, HS_POL = 1, VS_POL = 1:
  - VGA_CLK is high for 2 cycles and low for 2;
  - HS is high-asserted;
  - the line is 480 pixels = 1920 clk50m.
